sdram_tester: RTL and testbench

- Avalon-MM burst master placed directly upstream of the SDRAM controller; drives its slave port (read, write, address, writedata, burstcount, byteenable) and consumes waitrequest, readdatavalid and readdata.
- On start, writes an address-derived pattern over a word region in fixed-length bursts, then reads the region back in bursts and compares every word.
- Reports pass/fail, error count, first failing address and a watchdog timeout; summarises status on the board LEDs.

---
 rtl/sdram_pkg.sv | 23 ++
 rtl/sdram_tester_if.sv | 27 ++
 rtl/sdram_tst_watchdog.sv | 32 +++
 rtl/sdram_tester.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_tester.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, tester state encoding and the address-derived
// test pattern used by the SDRAM tester and its bench.
package sdram_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int BC_W   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BURST,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } tst_state_e;

  // Data written to / expected from word address addr.
  function automatic logic [DATA_W-1:0] expected(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] pattern);
    return addr[DATA_W-1:0] ^ pattern;
  endfunction

endpackage

// File: rtl/sdram_tester_if.sv
// sdram_tester_if: Avalon-MM burst bus between the tester (master) and the
// SDRAM controller slave port.
//   read/write/address/writedata/burstcount/byteenable : master -> slave
//   waitrequest/readdatavalid/readdata                 : slave  -> master
interface sdram_tester_if;
  import sdram_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [BC_W-1:0]   burstcount;
  logic [1:0]        byteenable;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output read, write, address, writedata, burstcount, byteenable,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read, write, address, writedata, burstcount, byteenable,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/sdram_tst_watchdog.sv
// sdram_tst_watchdog: inactivity timer for the SDRAM tester.
//   clk, reset (sync, active-low)
//   clr   : reload the timer (activity seen, or tester not running)
//   en    : count while the tester waits on the bus
//   fired : TIMEOUT_CYC enabled cycles have passed since the last clr
module sdram_tst_watchdog #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Down-counter: terminal count 0 means the budget is used up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= RELOAD;
    end else if (clr) begin
      cnt <= RELOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign fired = en && !clr && (cnt == '0);
endmodule

// File: rtl/sdram_tester.sv
// sdram_tester: writes addr^PATTERN over [START_ADDR, END_ADDR) in fixed
// bursts, reads the region back and compares every word.
//   clk, reset (sync, active-low), start (one-cycle pulse, honoured in idle)
//   m      : Avalon-MM burst master port
//   busy, done, pass, timeout, err_count, first_err_addr : test status
//   led    : {done, pass, timeout, busy, err_count[3:0]}
//
// state      | meaning
// S_IDLE     | waiting for start, last results held
// S_WR_BURST | presenting write beats of the burst at base (gap = idle cycle)
// S_RD_CMD   | read command for the burst at base, held until accepted
// S_RD_DATA  | collecting and checking BURST read beats
// S_DONE     | results published, back to idle next cycle
module sdram_tester
  import sdram_pkg::*;
#(
  parameter int                BURST       = 8,
  parameter int                START_ADDR  = 0,
  parameter int                END_ADDR    = 4096,
  parameter logic [DATA_W-1:0] PATTERN     = 16'hA5A5,
  parameter int                TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  sdram_tester_if.master     m,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic [7:0]         led
);
  localparam int NUM_BURSTS = (END_ADDR - START_ADDR) / BURST;
  localparam logic [BC_W-1:0]   LAST_BEAT  = BC_W'(BURST - 1);
  localparam logic [23:0]       LAST_BURST = 24'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BASE0      = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST);

  tst_state_e        state, state_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [BC_W-1:0]   beat, beat_n;
  // Region end is detected by burst count so END_ADDR = 2^23 (wrapped to 0) works.
  logic [23:0]       burst_idx, burst_idx_n;
  logic              gap, gap_n;
  logic              busy_n, done_n, pass_n, timeout_n;
  logic [15:0]       err_count_n;
  logic [ADDR_W-1:0] first_err_addr_n;

  logic              wr_acc, rd_acc, rvalid, rd_err;
  logic [ADDR_W-1:0] word_addr;
  logic              wd_en, wd_clr, wd_fire;

  assign word_addr = base + ADDR_W'(beat);
  assign wr_acc    = m.write && !m.waitrequest;
  assign rd_acc    = m.read && !m.waitrequest;
  assign rvalid    = (state == S_RD_DATA) && m.readdatavalid;
  assign rd_err    = rvalid && (m.readdata != expected(word_addr, PATTERN));

  assign m.write      = (state == S_WR_BURST) && !gap;
  assign m.read       = (state == S_RD_CMD);
  assign m.address    = base;
  assign m.writedata  = m.write ? expected(word_addr, PATTERN) : '0;
  assign m.burstcount = BC_W'(BURST);
  assign m.byteenable = 2'b11;

  // Every entry into a bus-waiting state coincides with an accepted transfer,
  // so clearing on activity (and while not waiting) also covers state entry.
  assign wd_en  = (state == S_WR_BURST) || (state == S_RD_CMD) || (state == S_RD_DATA);
  assign wd_clr = !wd_en || wr_acc || rd_acc || rvalid;

  sdram_tst_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .fired (wd_fire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      base           <= '0;
      beat           <= '0;
      burst_idx      <= '0;
      gap            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      base           <= base_n;
      beat           <= beat_n;
      burst_idx      <= burst_idx_n;
      gap            <= gap_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      timeout        <= timeout_n;
      err_count      <= err_count_n;
      first_err_addr <= first_err_addr_n;
    end
  end

  always_comb begin
    state_n          = state;
    base_n           = base;
    beat_n           = beat;
    burst_idx_n      = burst_idx;
    gap_n            = gap;
    busy_n           = busy;
    done_n           = done;
    pass_n           = pass;
    timeout_n        = timeout;
    err_count_n      = err_count;
    first_err_addr_n = first_err_addr;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n          = S_WR_BURST;
          base_n           = BASE0;
          beat_n           = '0;
          burst_idx_n      = '0;
          gap_n            = 1'b0;
          busy_n           = 1'b1;
          done_n           = 1'b0;
          pass_n           = 1'b0;
          timeout_n        = 1'b0;
          err_count_n      = '0;
          first_err_addr_n = '0;
        end
      end
      S_WR_BURST: begin
        if (gap) begin
          gap_n = 1'b0;
        end else if (wr_acc) begin
          if (beat == LAST_BEAT) begin
            beat_n = '0;
            if (burst_idx == LAST_BURST) begin
              base_n      = BASE0;
              burst_idx_n = '0;
              state_n     = S_RD_CMD;
            end else begin
              base_n      = base + STEP;
              burst_idx_n = burst_idx + 24'd1;
              gap_n       = 1'b1;
            end
          end else begin
            beat_n = beat + BC_W'(1);
          end
        end
      end
      S_RD_CMD: begin
        if (rd_acc) begin
          state_n = S_RD_DATA;
          beat_n  = '0;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          if (rd_err) begin
            if (err_count == '0) first_err_addr_n = word_addr;
            if (err_count != 16'hFFFF) err_count_n = err_count + 16'd1;
          end
          if (beat == LAST_BEAT) begin
            beat_n = '0;
            if (burst_idx == LAST_BURST) begin
              state_n = S_DONE;
            end else begin
              base_n      = base + STEP;
              burst_idx_n = burst_idx + 24'd1;
              state_n     = S_RD_CMD;
            end
          end else begin
            beat_n = beat + BC_W'(1);
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (wd_fire) begin
      timeout_n = 1'b1;
      state_n   = S_DONE;
    end

    // Results become visible during the DONE cycle itself.
    if (state_n == S_DONE && state != S_DONE) begin
      busy_n = 1'b0;
      done_n = 1'b1;
      pass_n = (err_count_n == '0) && !timeout_n;
    end
  end

  assign led = {done, pass, timeout, busy, err_count[3:0]};
endmodule

// File: tb/tb_sdram_tester.sv
// Bench for sdram_tester: 32-word region, BURST=8, TIMEOUT_CYC=50, with a
// behavioural SDRAM slave (optional stalls, corruption, silent reads) and a
// scoreboard of expected write beats and expected end-of-test results.
module tb_sdram_tester;
  import sdram_pkg::*;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err;
    logic [22:0] first;
    logic [7:0]  led;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [22:0] first_err_addr;
  logic [7:0]  led;

  sdram_tester_if bus();

  sdram_tester #(
    .BURST(8), .START_ADDR(0), .END_ADDR(32), .PATTERN(16'hA5A5), .TIMEOUT_CYC(50)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .m              (bus.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .led            (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // scoreboard queues
  logic [22:0] exp_waddr_q[$];
  logic [15:0] exp_wdata_q[$];
  res_t        exp_res_q[$];

  // slave model state
  bit          stall_en = 0, corrupt = 0, no_rvalid = 0;
  int          wr_count = 0, rd_cmds = 0, wbeat = 0, stall_run = 0, cycle = 0;
  int          rd_left = 0, rd_delay = 0, acc_cycle = 0, done_cycle = 0;
  logic [22:0] rd_addr, wa, prev_addr;
  logic [15:0] mem [32];
  logic [15:0] d, prev_data;
  logic        prev_stall = 0, prev_done = 0;
  res_t        er;

  // Slave + monitor, on the falling edge: first drive the responses that the
  // next rising edge will see, then record the transfers that edge completes.
  always @(negedge clk) begin
    cycle++;
    if (rd_left > 0 && rd_delay == 0 && !no_rvalid) begin
      d = mem[rd_addr[4:0]];
      if (corrupt && (rd_addr == 23'd5 || rd_addr == 23'd17)) d[0] = 1'b1;
      bus.readdatavalid = 1'b1;
      bus.readdata      = d;
      rd_addr++;
      rd_left--;
    end else begin
      bus.readdatavalid = 1'b0;
      bus.readdata      = '0;
      if (rd_delay > 0) rd_delay--;
    end
    if (stall_en && stall_run < 3 && $urandom_range(0, 1) == 1) begin
      bus.waitrequest = 1'b1;
      stall_run++;
    end else begin
      bus.waitrequest = 1'b0;
      stall_run = 0;
    end

    if (reset) begin
      if (prev_stall) begin
        chk("stall_hold_write", 32'(bus.write), 32'd1);
        chk("stall_hold_data", 32'(bus.writedata), 32'(prev_data));
        chk("stall_hold_addr", 32'(bus.address), 32'(prev_addr));
      end
      prev_stall = bus.write && bus.waitrequest;
      prev_data  = bus.writedata;
      prev_addr  = bus.address;

      if (bus.write && !bus.waitrequest) begin
        wa = bus.address + 23'(wbeat);
        if (exp_waddr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h, none expected", wa);
        end else begin
          chk("wr_addr", 32'(wa), 32'(exp_waddr_q.pop_front()));
          chk("wr_data", 32'(bus.writedata), 32'(exp_wdata_q.pop_front()));
        end
        chk("wr_burstcount", 32'(bus.burstcount), 32'd8);
        chk("wr_byteenable", 32'(bus.byteenable), 32'd3);
        mem[wa[4:0]] = bus.writedata;
        wr_count++;
        wbeat = (wbeat == 7) ? 0 : wbeat + 1;
      end

      if (bus.read && !bus.waitrequest) begin
        rd_addr   = bus.address;
        rd_left   = 8;
        rd_delay  = 2;
        rd_cmds++;
        acc_cycle = cycle;
      end

      if (done && !prev_done) begin
        done_cycle = cycle;
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done rose with no result expected");
        end else begin
          er = exp_res_q.pop_front();
          chk("res_done", 32'(done), 32'(er.done));
          chk("res_pass", 32'(pass), 32'(er.pass));
          chk("res_timeout", 32'(timeout), 32'(er.timeout));
          chk("res_err_count", 32'(err_count), 32'(er.err));
          chk("res_first_err_addr", 32'(first_err_addr), 32'(er.first));
          chk("res_led", 32'(led), 32'(er.led));
        end
      end
      prev_done = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      wbeat      = 0;
      rd_left    = 0;
    end
  end

  function automatic res_t mk_res(input logic dn, input logic ps, input logic to,
                                  input logic [15:0] er_c, input logic [22:0] fa,
                                  input logic [7:0] ld);
    res_t r;
    r.done = dn; r.pass = ps; r.timeout = to; r.err = er_c; r.first = fa; r.led = ld;
    return r;
  endfunction

  task automatic arm(input bit corr, input bit nrv, input bit stl, input res_t exp);
    corrupt   = corr;
    no_rvalid = nrv;
    stall_en  = stl;
    wr_count  = 0;
    rd_cmds   = 0;
    for (int a = 0; a < 32; a++) begin
      exp_waddr_q.push_back(23'(a));
      exp_wdata_q.push_back(16'(a) ^ 16'hA5A5);
    end
    exp_res_q.push_back(exp);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, n);
    end
    repeat (2) @(negedge clk);
    chk("res_seen", 32'(exp_res_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write"}, 32'(bus.write), 32'd0);
    chk({tag, "_read"}, 32'(bus.read), 32'd0);
    chk({tag, "_address"}, 32'(bus.address), 32'd0);
    chk({tag, "_writedata"}, 32'(bus.writedata), 32'd0);
    chk({tag, "_burstcount"}, 32'(bus.burstcount), 32'd8);
    chk({tag, "_byteenable"}, 32'(bus.byteenable), 32'd3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
    chk({tag, "_led"}, 32'(led), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    #1 reset = 1'b1;

    // 1: ideal slave
    arm(0, 0, 0, mk_res(1, 1, 0, 16'd0, 23'd0, 8'b1100_0000));
    pulse_start();
    wait_done();
    chk("t1_writes", 32'(wr_count), 32'd32);
    chk("t1_read_cmds", 32'(rd_cmds), 32'd4);
    chk("t1_word5", 32'(mem[5]), 32'h0000_A5A0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: corrupted words 5 and 17
    arm(1, 0, 0, mk_res(1, 0, 0, 16'd2, 23'd5, 8'b1000_0010));
    pulse_start();
    wait_done();

    // 3: random stalls on write and read
    arm(0, 0, 1, mk_res(1, 1, 0, 16'd0, 23'd0, 8'b1100_0000));
    pulse_start();
    wait_done();
    chk("t3_writes", 32'(wr_count), 32'd32);
    chk("t3_read_cmds", 32'(rd_cmds), 32'd4);

    // 4: read data never returns
    arm(0, 1, 0, mk_res(1, 0, 1, 16'd0, 23'd0, 8'b1010_0000));
    pulse_start();
    wait_done();
    chk("t4_read_low", 32'(bus.read), 32'd0);
    chk("t4_read_cmds", 32'(rd_cmds), 32'd1);
    chk("t4_timeout_delay", 32'((done_cycle - acc_cycle) >= 45 && (done_cycle - acc_cycle) <= 60), 32'd1);
    no_rvalid = 0;
    rd_left   = 0;

    // 5: reset during the third write burst, then rerun
    arm(0, 0, 0, mk_res(1, 1, 0, 16'd0, 23'd0, 8'b1100_0000));
    pulse_start();
    n = 0;
    while (wr_count < 18 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_burst3", 32'(wr_count >= 18), 32'd1);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk); #1 reset = 1'b1;
    exp_waddr_q.delete();
    exp_wdata_q.delete();
    exp_res_q.delete();
    arm(0, 0, 0, mk_res(1, 1, 0, 16'd0, 23'd0, 8'b1100_0000));
    pulse_start();
    wait_done();
    chk("t5_rerun_writes", 32'(wr_count), 32'd32);

    // 6: start while busy is ignored
    arm(0, 0, 0, mk_res(1, 1, 0, 16'd0, 23'd0, 8'b1100_0000));
    pulse_start();
    repeat (20) @(negedge clk);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    pulse_start();
    wait_done();
    chk("t6_writes", 32'(wr_count), 32'd32);
    chk("t6_read_cmds", 32'(rd_cmds), 32'd4);

    // 7: start coincident with reset: reset wins
    wr_count = 0;
    @(negedge clk); #1 start = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    @(negedge clk); #1 start = 1'b0; reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_still_idle", 32'(busy), 32'd0);
    chk("t7_no_writes", 32'(wr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global time limit reached");
  end
endmodule
